// File: rtl/serial_add_8_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// master = producer/consumer side, slave = adder side.
interface serial_add_8_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/serial_add_8.sv
// Bit-serial adder: {co, sum} = a + b + ci, one bit per clock, LSB first,
// with independent valid/ready handshakes on operands and result.
module serial_add_8 #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_add_8_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_out_valid;

  logic w_s;
  logic w_cy;

  assign w_s  = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_cy = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_co        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_carry <= bus.ci;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_carry <= w_cy;
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; sum/co then hold until
          // the next completed operation, independent of the shift state.
          if (!r_out_valid) begin
            r_sum       <= r_res;
            r_co        <= r_carry;
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.co        = r_co;
endmodule

// File: tb/tb_serial_add_8.sv
// Directed and randomized scoreboard bench for serial_add_8 (WIDTH=8 and WIDTH=2).
module tb_serial_add_8;
  logic clk;
  logic rst;

  serial_add_8_if #(.WIDTH(8)) bus ();
  serial_add_8_if #(.WIDTH(2)) bus2 ();

  serial_add_8 #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  serial_add_8 #(.WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [8:0]  sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand set, wait for the result and compare against the queue head.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic rdy, input string tag);
    int unsigned n;
    logic [8:0]  exp;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.ci        = ci;
    bus.out_ready = rdy;
    sb.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 32'd9);
    exp = sb.pop_front();
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp[7:0]));
    check({tag, "_co"}, 32'(bus.co), 32'(exp[8]));
    if (rdy) begin
      @(negedge clk);
      check({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [7:0]  hold_sum;
    logic        hold_co;
    logic [8:0]  exp;
    int unsigned n;
    int unsigned cycles;
    int unsigned n_acc;
    int unsigned n_done;
    int unsigned last_acc;
    logic        acc_last;
    logic        prev_ov;
    logic        prev_or;
    logic [7:0]  prev_sum;
    logic        prev_co;
    logic        stuck;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.ci         = 1'b0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.a         = '0;
    bus2.b         = '0;
    bus2.ci        = 1'b0;
    bus2.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_co", 32'(bus.co), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic and wrap-around operations
    do_op(8'h5A, 8'h3C, 1'b0, 1'b1, "t1");
    do_op(8'hFF, 8'h01, 1'b0, 1'b1, "t2a");
    do_op(8'hFF, 8'hFF, 1'b1, 1'b1, "t2b");
    do_op(8'h00, 8'h00, 1'b1, 1'b1, "t2c");

    // Backpressure: result must hold while out_ready is low
    do_op(8'h12, 8'h34, 1'b1, 1'b0, "t3");
    hold_sum = bus.sum;
    hold_co  = bus.co;
    bus.in_valid = 1'b1;
    bus.a        = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_ov", 32'(bus.out_valid), 32'd1);
      check("t3_hold_sum", 32'(bus.sum), 32'(hold_sum));
      check("t3_hold_co", 32'(bus.co), 32'(hold_co));
      check("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ov", 32'(bus.out_valid), 32'd0);
    stuck = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) stuck = 1'b1;
    end
    check("t3_no_spurious_accept", 32'(stuck), 32'd0);

    // Reset in the middle of RUN (cnt == 3)
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'h77;
    bus.b        = 8'h11;
    bus.ci       = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4_ov", 32'(bus.out_valid), 32'd0);
    check("t4_sum", 32'(bus.sum), 32'd0);
    check("t4_co", 32'(bus.co), 32'd0);
    check("t4_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(8'h10, 8'h20, 1'b0, 1'b1, "t4_fresh");

    // Back-to-back randomized run with random backpressure
    cycles   = 0;
    n_acc    = 0;
    n_done   = 0;
    last_acc = 0;
    acc_last = 1'b0;
    prev_ov  = 1'b0;
    prev_or  = 1'b0;
    prev_sum = '0;
    prev_co  = 1'b0;
    @(negedge clk);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.ci       = 1'($urandom);
    bus.in_valid = 1'b1;
    while (n_done < 1000 && cycles < 60000) begin
      if (cycles > 0) @(negedge clk);
      cycles++;
      if (acc_last) begin
        acc_last = 1'b0;
        if (n_acc < 1000) begin
          bus.a  = 8'($urandom);
          bus.b  = 8'($urandom);
          bus.ci = 1'($urandom);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (prev_ov && !prev_or) begin
        check("t5_stable_ov", 32'(bus.out_valid), 32'd1);
        check("t5_stable_sum", 32'({bus.co, bus.sum}), 32'({prev_co, prev_sum}));
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("t5_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("t5_result", 32'({bus.co, bus.sum}), 32'(exp));
        end
        n_done++;
      end
      prev_ov  = bus.out_valid;
      prev_or  = bus.out_ready;
      prev_sum = bus.sum;
      prev_co  = bus.co;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({1'b0, bus.a} + {1'b0, bus.b} + {8'd0, bus.ci});
        if (n_acc > 0) begin
          check("t5_spacing_ok", 32'(cycles - last_acc >= 10), 32'd1);
        end
        last_acc = cycles;
        n_acc++;
        acc_last = 1'b1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("t5_done_count", n_done, 32'd1000);
    check("t5_accept_count", n_acc, 32'd1000);
    check("t5_queue_empty", sb.size(), 32'd0);

    // WIDTH=2 instance
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.a        = 2'd3;
    bus2.b        = 2'd3;
    bus2.ci       = 1'b1;
    check("t6_in_ready", 32'(bus2.in_ready), 32'd1);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    n = 0;
    while (!bus2.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_latency", n, 32'd3);
    check("t6_sum", 32'(bus2.sum), 32'd3);
    check("t6_co", 32'(bus2.co), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
